// File: rtl/car_lane_controller.sv
// car_lane_controller
//   Four-lane car position generator for the sprite display stage. Cars step
//   once per frame during vertical blanking, at a rate set by lane and level.
//   Optional frog/car overlap flag: define COLLISION_DETECT_EN to build it;
//   without it o_Hit is tied low and the frog position ports are ignored.

module car_lane_controller #(
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned CAR_STEP       = 2,
  parameter int unsigned BASE_PERIOD    = 4,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter logic [3:0]  REVERSE_INIT   = 4'b0101,
  parameter int unsigned LINE_1_Y       = 64,
  parameter int unsigned LINE_2_Y       = 128,
  parameter int unsigned LINE_3_Y       = 192,
  parameter int unsigned LINE_4_Y       = 256
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_H_Counter,
  input  logic [9:0] i_V_Counter,
  input  logic       i_Level_Up,
  input  logic       i_Game_Restart,
  input  logic [9:0] i_X_Position,
  input  logic [8:0] i_Y_Position,
  output logic [9:0] o_Car_1X,
  output logic [9:0] o_Car_2X,
  output logic [9:0] o_Car_3X,
  output logic [9:0] o_Car_4X,
  output logic [3:0] o_Reverse,
  output logic [1:0] o_Level,
  output logic       o_Frame_Tick,
  output logic       o_Hit
);

  localparam int unsigned LANES = 4;
  // Counter must hold the longest lane period minus one (BASE_PERIOD + 2).
  localparam int unsigned CNT_W = $clog2(BASE_PERIOD + 4);

  logic             tick;
  logic             level_pending;
  logic [1:0]       level_next;
  logic [9:0]       car_x     [LANES];
  logic [9:0]       step_x    [LANES];
  logic [10:0]      right_sum [LANES];
  logic [10:0]      left_sum  [LANES];
  logic [CNT_W-1:0] frame_cnt [LANES];
  logic [CNT_W-1:0] period_m1 [LANES];
  logic [LANES-1:0] do_step;

  assign tick      = (i_H_Counter == 10'd0) && (i_V_Counter == 10'(V_VISIBLE_AREA));
  assign o_Reverse = REVERSE_INIT;
  assign o_Car_1X  = car_x[0];
  assign o_Car_2X  = car_x[1];
  assign o_Car_3X  = car_x[2];
  assign o_Car_4X  = car_x[3];

  // Saturating level increment applied on a tick when a level-up is pending.
  always_comb begin
    level_next = (o_Level == 2'(MAX_LEVEL)) ? o_Level : o_Level + 2'd1;
  end

  // Per-lane step decision and wrapped next position; period uses pre-update level.
  always_comb begin
    for (int unsigned n = 0; n < LANES; n++) begin
      period_m1[n] = CNT_W'(BASE_PERIOD - 1 + n) - CNT_W'(o_Level);
      do_step[n]   = (frame_cnt[n] >= period_m1[n]);
      right_sum[n] = {1'b0, car_x[n]} + 11'(CAR_STEP);
      left_sum[n]  = {1'b0, car_x[n]} + 11'(H_VISIBLE_AREA) - 11'(CAR_STEP);
      if (REVERSE_INIT[n]) begin
        step_x[n] = (right_sum[n] >= 11'(H_VISIBLE_AREA))
                  ? 10'(right_sum[n] - 11'(H_VISIBLE_AREA))
                  : right_sum[n][9:0];
      end else begin
        step_x[n] = (car_x[n] < 10'(CAR_STEP))
                  ? left_sum[n][9:0]
                  : car_x[n] - 10'(CAR_STEP);
      end
    end
  end

`ifdef COLLISION_DETECT_EN
  localparam logic [8:0] LINE_Y [LANES] = '{9'(LINE_1_Y), 9'(LINE_2_Y), 9'(LINE_3_Y), 9'(LINE_4_Y)};

  logic       hit_any;
  logic [9:0] dx [LANES];
  logic [8:0] dy [LANES];

  // Frog overlaps any car (pre-step positions, no wrap-around check).
  always_comb begin
    hit_any = 1'b0;
    for (int unsigned n = 0; n < LANES; n++) begin
      dx[n] = (i_X_Position >= car_x[n]) ? i_X_Position - car_x[n] : car_x[n] - i_X_Position;
      dy[n] = (i_Y_Position >= LINE_Y[n]) ? i_Y_Position - LINE_Y[n] : LINE_Y[n] - i_Y_Position;
      if ((dx[n] < 10'(TILE_SIZE)) && (dy[n] < 9'(TILE_SIZE))) hit_any = 1'b1;
    end
  end
`else
  logic unused_frog;
  assign unused_frog = ^{i_X_Position, i_Y_Position};
  assign o_Hit       = 1'b0;
`endif

  // Game state: positions, frame counters, level and pulse outputs, updated only on tick.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        car_x[n]     <= 10'(n * H_VISIBLE_AREA / 4);
        frame_cnt[n] <= '0;
      end
      o_Level       <= '0;
      level_pending <= 1'b0;
      o_Frame_Tick  <= 1'b0;
`ifdef COLLISION_DETECT_EN
      o_Hit         <= 1'b0;
`endif
    end else if (i_Game_Restart) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        car_x[n]     <= 10'(n * H_VISIBLE_AREA / 4);
        frame_cnt[n] <= '0;
      end
      o_Level       <= '0;
      level_pending <= 1'b0;
      o_Frame_Tick  <= 1'b0;
`ifdef COLLISION_DETECT_EN
      o_Hit         <= 1'b0;
`endif
    end else begin
      o_Frame_Tick <= tick;
`ifdef COLLISION_DETECT_EN
      o_Hit        <= tick && hit_any;
`endif
      if (tick) begin
        for (int unsigned n = 0; n < LANES; n++) begin
          if (do_step[n]) begin
            car_x[n]     <= step_x[n];
            frame_cnt[n] <= '0;
          end else begin
            frame_cnt[n] <= frame_cnt[n] + 1'b1;
          end
        end
        if (level_pending) o_Level <= level_next;
        // A pulse landing on the tick cycle itself is carried into the next frame.
        level_pending <= i_Level_Up;
      end else if (i_Level_Up) begin
        level_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_car_lane_controller.sv
// tb_car_lane_controller
//   Directed bench for car_lane_controller. Frame ticks are produced by
//   holding H=0, V=480 for one clock; inputs change and outputs are sampled
//   on the falling edge. Define COLLISION_DETECT_EN for the overlap checks.

module tb_car_lane_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt, v_cnt;
  logic       level_up, restart;
  logic [9:0] frog_x;
  logic [8:0] frog_y;
  logic [9:0] car1, car2, car3, car4;
  logic [3:0] reverse;
  logic [1:0] level;
  logic       frame_tick, hit;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  car_lane_controller dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_H_Counter    (h_cnt),
    .i_V_Counter    (v_cnt),
    .i_Level_Up     (level_up),
    .i_Game_Restart (restart),
    .i_X_Position   (frog_x),
    .i_Y_Position   (frog_y),
    .o_Car_1X       (car1),
    .o_Car_2X       (car2),
    .o_Car_3X       (car3),
    .o_Car_4X       (car4),
    .o_Reverse      (reverse),
    .o_Level        (level),
    .o_Frame_Tick   (frame_tick),
    .o_Hit          (hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-clock frame tick; returns at the falling edge after the update edge.
  task automatic do_tick();
    @(negedge clk);
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    @(negedge clk);
    h_cnt = 10'd1;
    v_cnt = 10'd0;
  endtask

  task automatic pulse_level_up();
    @(negedge clk);
    level_up = 1'b1;
    @(negedge clk);
    level_up = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    h_cnt    = 10'd100;
    v_cnt    = 10'd10;
    level_up = 1'b0;
    restart  = 1'b0;
    frog_x   = 10'd400;
    frog_y   = 9'd400;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_car1", car1, 0);
    check("rst_car4", car4, 480);
    check("rst_level", level, 0);

    // Default speeds: lane 1 right P=4, lane 2 left P=5, lane 3 right P=6, lane 4 left P=7.
    repeat (3) do_tick();
    check("t3_car1", car1, 0);
    check("t3_frame_tick", frame_tick, 1);
    @(negedge clk);
    check("frame_tick_clear", frame_tick, 0);
    do_tick();
    check("t4_car1", car1, 2);
    check("t4_car2", car2, 160);
    do_tick();
    check("t5_car2", car2, 158);
    do_tick();
    check("t6_car3", car3, 322);
    check("t6_car4", car4, 480);
    do_tick();
    check("t7_car4", car4, 478);
    check("t7_car1", car1, 2);

    // Asynchronous reset mid-line, between clock edges.
    h_cnt = 10'd200;
    v_cnt = 10'd77;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_car1", car1, 0);
    check("arst_car2", car2, 160);
    check("arst_car3", car3, 320);
    check("arst_car4", car4, 480);
    check("arst_reverse", reverse, 4'b0101);
    check("arst_level", level, 0);
    check("arst_frame_tick", frame_tick, 0);
    check("arst_hit", hit, 0);
    @(negedge clk);
    rst = 1'b0;

    // Level ramp, one request per frame; period shrinks under the running count.
    pulse_level_up();
    do_tick();
    check("lvl1", level, 1);
    pulse_level_up();
    do_tick();
    check("lvl2", level, 2);
    pulse_level_up();
    do_tick();
    check("lvl3", level, 3);
    check("lvl3_car1", car1, 2);
    check("lvl3_car2", car2, 158);
    pulse_level_up();
    do_tick();
    check("lvl_sat", level, 3);
    check("lvl_sat_car1", car1, 4);
    do_tick();
    check("lvl3_car1_next", car1, 6);
    check("lvl3_car2_next", car2, 156);

    // Wrap: lane 2 (P=2) reaches 0 then wraps left; lane 1 (P=1) wraps right.
    repeat (156) do_tick();
    check("car2_at_0", car2, 0);
    check("car1_mid", car1, 318);
    repeat (2) do_tick();
    check("car2_wrap", car2, 638);
    repeat (158) do_tick();
    check("car1_at_638", car1, 638);
    do_tick();
    check("car1_wrap", car1, 0);

    // Level-up and restart in the same cycle: restart wins, nothing pending.
    @(negedge clk);
    level_up = 1'b1;
    restart  = 1'b1;
    @(negedge clk);
    level_up = 1'b0;
    restart  = 1'b0;
    check("restart_level", level, 0);
    check("restart_car1", car1, 0);
    check("restart_car2", car2, 160);
    do_tick();
    check("restart_no_pending", level, 0);
    check("restart_car1_hold", car1, 0);

    // Several requests in one frame count once.
    pulse_level_up();
    pulse_level_up();
    do_tick();
    check("multi_pulse_once", level, 1);
    do_tick();
    check("multi_pulse_no_carry", level, 1);

    // Overlap flag with car 1 at X=0 (lane 1 just restarted, no step within two ticks).
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    frog_x  = 10'd10;
    frog_y  = 9'd64;
    do_tick();
`ifdef COLLISION_DETECT_EN
    check("hit_overlap", hit, 1);
`else
    check("hit_tied_low", hit, 0);
`endif
    @(negedge clk);
    check("hit_one_cycle", hit, 0);
    frog_x = 10'd40;
    do_tick();
    check("hit_clear_x40", hit, 0);
    check("hit_car1_pos", car1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
